// File: rtl/neorv32_wb_bridge_pkg.sv
// neorv32_wb_bridge_pkg: shared types for the neorv32 bus to Wishbone bridge
package neorv32_wb_bridge_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef enum logic {SEL_IBUS, SEL_DBUS} port_sel_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic        rw;
    } bus_req_t;
    localparam logic [3:0] BEN_ALL = 4'hF;
endpackage

// File: rtl/neorv32_wb_bridge_if.sv
// neorv32_wb_bridge_if: CPU ibus/dbus request-response ports plus the Wishbone initiator bus
interface neorv32_wb_bridge_if;
    logic        ibus_req_stb;
    logic [31:0] ibus_req_addr;
    logic [31:0] ibus_rsp_data;
    logic        ibus_rsp_ack;
    logic        ibus_rsp_err;
    logic        dbus_req_stb;
    logic        dbus_req_rw;
    logic [31:0] dbus_req_addr;
    logic [31:0] dbus_req_data;
    logic [3:0]  dbus_req_ben;
    logic [31:0] dbus_rsp_data;
    logic        dbus_rsp_ack;
    logic        dbus_rsp_err;
    logic        core_cyc;
    logic        core_stb;
    logic        core_we;
    logic [3:0]  core_wstrb;
    logic [31:0] core_addr;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in;
    logic        core_ack;
    modport slave (
        input  ibus_req_stb, ibus_req_addr,
        output ibus_rsp_data, ibus_rsp_ack, ibus_rsp_err,
        input  dbus_req_stb, dbus_req_rw, dbus_req_addr, dbus_req_data, dbus_req_ben,
        output dbus_rsp_data, dbus_rsp_ack, dbus_rsp_err,
        output core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
        input  core_data_in, core_ack
    );
    modport master (
        output ibus_req_stb, ibus_req_addr,
        input  ibus_rsp_data, ibus_rsp_ack, ibus_rsp_err,
        output dbus_req_stb, dbus_req_rw, dbus_req_addr, dbus_req_data, dbus_req_ben,
        input  dbus_rsp_data, dbus_rsp_ack, dbus_rsp_err,
        input  core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
        output core_data_in, core_ack
    );
endinterface

// File: rtl/neorv32_wb_req_latch.sv
// neorv32_wb_req_latch: holds one port's outstanding request until its response is issued
module neorv32_wb_req_latch
    import neorv32_wb_bridge_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     stb,
    input  bus_req_t req_in,
    input  logic     clr,
    output logic     pending,
    output bus_req_t req
);
    logic     pend_q, pend_d;
    bus_req_t req_q, req_d;

    // a re-strobe while still outstanding is dropped so the in-flight fields stay intact
    always_comb begin
        pend_d = (pend_q & ~clr) | (stb & ~pend_q);
        req_d  = (stb && !pend_q) ? req_in : req_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            req_q  <= '0;
        end else begin
            pend_q <= pend_d;
            req_q  <= req_d;
        end
    end

    assign pending = pend_q;
    assign req     = req_q;

    a_no_restrobe: assert property (@(posedge clk) disable iff (rst) !(stb && pend_q));
endmodule

// File: rtl/neorv32_wb_bridge.sv
// neorv32_wb_bridge: arbitrates neorv32 ibus/dbus requests onto one Wishbone-classic initiator
module neorv32_wb_bridge
    import neorv32_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DBUS_PRIORITY  = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    neorv32_wb_bridge_if.slave  bus
);
    state_t      state_q, state_d;
    port_sel_t   sel_q, sel_d;
    logic [31:0] cnt_q, cnt_d, rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        i_ack_q, i_ack_d, i_err_q, i_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0] i_data_q, i_data_d, d_data_q, d_data_d;
    logic        i_pend, d_pend, i_clr, d_clr, i_any, d_any, in_bus, fire;
    bus_req_t    i_req, d_req, req;

    neorv32_wb_req_latch u_ilatch (
        .clk     (clk),
        .rst     (rst),
        .stb     (bus.ibus_req_stb),
        .req_in  ('{addr: bus.ibus_req_addr, data: 32'h0, ben: BEN_ALL, rw: 1'b0}),
        .clr     (i_clr),
        .pending (i_pend),
        .req     (i_req)
    );

    neorv32_wb_req_latch u_dlatch (
        .clk     (clk),
        .rst     (rst),
        .stb     (bus.dbus_req_stb),
        .req_in  ('{addr: bus.dbus_req_addr, data: bus.dbus_req_data, ben: bus.dbus_req_ben, rw: bus.dbus_req_rw}),
        .clr     (d_clr),
        .pending (d_pend),
        .req     (d_req)
    );

    // a strobe arriving in IDLE is granted the same cycle; its fields are read from the latch once in BUS
    assign i_any = i_pend | bus.ibus_req_stb;
    assign d_any = d_pend | bus.dbus_req_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= SEL_IBUS;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            i_ack_q  <= 1'b0;
            i_err_q  <= 1'b0;
            i_data_q <= '0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            d_data_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            i_ack_q  <= i_ack_d;
            i_err_q  <= i_err_d;
            i_data_q <= i_data_d;
            d_ack_q  <= d_ack_d;
            d_err_q  <= d_err_d;
            d_data_q <= d_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (i_any || d_any) begin
                state_d = BUS;
                sel_d   = (d_any && (DBUS_PRIORITY || !i_any)) ? SEL_DBUS : SEL_IBUS;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            BUS: if (bus.core_ack) begin
                state_d = RESP;
                rdata_d = bus.core_data_in;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
                state_d = RESP;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // responses are registered out of RESP, so the pulse lands one cycle after RESP
    always_comb begin
        req      = (sel_q == SEL_DBUS) ? d_req : i_req;
        in_bus   = state_q == BUS;
        fire     = state_q == RESP;
        i_clr    = fire && sel_q == SEL_IBUS;
        d_clr    = fire && sel_q == SEL_DBUS;
        i_ack_d  = i_clr && !err_q;
        i_err_d  = i_clr && err_q;
        d_ack_d  = d_clr && !err_q;
        d_err_d  = d_clr && err_q;
        i_data_d = i_clr ? (err_q ? '0 : rdata_q) : i_data_q;
        d_data_d = d_clr ? ((err_q || req.rw) ? '0 : rdata_q) : d_data_q;
    end

    assign bus.core_cyc      = in_bus;
    assign bus.core_stb      = in_bus;
    assign bus.core_we       = in_bus & req.rw;
    assign bus.core_wstrb    = in_bus ? (req.rw ? req.ben : BEN_ALL) : 4'h0;
    assign bus.core_addr     = in_bus ? {req.addr[31:2], 2'b00} : 32'h0;
    assign bus.core_data_out = in_bus ? req.data : 32'h0;
    assign bus.ibus_rsp_ack  = i_ack_q;
    assign bus.ibus_rsp_err  = i_err_q;
    assign bus.ibus_rsp_data = i_data_q;
    assign bus.dbus_rsp_ack  = d_ack_q;
    assign bus.dbus_rsp_err  = d_err_q;
    assign bus.dbus_rsp_data = d_data_q;
endmodule

// File: tb/tb_neorv32_wb_bridge.sv
// tb_neorv32_wb_bridge: directed and randomized scenarios against a cycle-timing reference model
module tb_neorv32_wb_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neorv32_wb_bridge_if b();
    neorv32_wb_bridge #(.TIMEOUT_CYCLES(8), .DBUS_PRIORITY(1'b1)) dut (.clk(clk), .rst(rst), .bus(b));

    typedef struct {logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] wstrb;} tx_t;
    tx_t log_q[$];
    int checks = 0, errors = 0;
    bit mem_en = 1'b1, stray_ack = 1'b0;
    int ack_wait = 0, wcnt = 0, unstable = 0;
    logic        ph_we;
    logic [31:0] ph_addr, ph_data;
    logic [3:0]  ph_wstrb;
    int i_acks, i_errs, d_acks, d_errs, i_t, d_t, de_t, cyc_hi, cyc_first, phases;
    logic [31:0] i_dat, d_dat;
    logic prev_cyc;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : {a[15:0] ^ 16'hA5A5, a[31:16] + 16'h1357};
    endfunction

    // memory: acks after ack_wait extra cycles of cyc, logs every transfer, flags unstable fields
    initial begin
        b.core_ack = 1'b0;
        b.core_data_in = '0;
        forever begin
            @(posedge clk);
            #2;
            if (b.core_cyc) begin
                if (wcnt == 0) begin
                    ph_we = b.core_we; ph_addr = b.core_addr; ph_data = b.core_data_out; ph_wstrb = b.core_wstrb;
                end else if (ph_we !== b.core_we || ph_addr !== b.core_addr || ph_data !== b.core_data_out || ph_wstrb !== b.core_wstrb) begin
                    unstable++;
                end
                if (mem_en && wcnt == ack_wait) begin
                    b.core_ack = 1'b1;
                    b.core_data_in = b.core_we ? $urandom : mem_rd(b.core_addr);
                    log_q.push_back(tx_t'{we: b.core_we, addr: b.core_addr, data: b.core_data_out, wstrb: b.core_wstrb});
                    wcnt = 0;
                end else begin
                    b.core_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                b.core_ack = stray_ack;
                b.core_data_in = $urandom;
                wcnt = 0;
            end
        end
    end

    task automatic set_i(input logic [31:0] a);
        b.ibus_req_addr = a;
    endtask

    task automatic set_d(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] ben);
        b.dbus_req_rw = rw; b.dbus_req_addr = a; b.dbus_req_data = d; b.dbus_req_ben = ben;
    endtask

    // pulses strobes at cycle offsets i_at/d_at and records what comes back over n cycles
    task automatic run(input int i_at, input int d_at, input int n);
        i_acks = 0; i_errs = 0; d_acks = 0; d_errs = 0; i_t = -1; d_t = -1; de_t = -1;
        cyc_hi = 0; cyc_first = -1; phases = 0; prev_cyc = 1'b0;
        for (int c = 0; c < n; c++) begin
            b.ibus_req_stb = (c == i_at);
            b.dbus_req_stb = (c == d_at);
            @(negedge clk);
            if (b.ibus_rsp_ack) begin i_acks++; i_t = c; i_dat = b.ibus_rsp_data; end
            if (b.ibus_rsp_err) i_errs++;
            if (b.dbus_rsp_ack) begin d_acks++; d_t = c; d_dat = b.dbus_rsp_data; end
            if (b.dbus_rsp_err) begin d_errs++; de_t = c; end
            if (b.core_cyc) begin
                cyc_hi++;
                if (cyc_first < 0) cyc_first = c;
                if (!prev_cyc) phases++;
            end
            prev_cyc = b.core_cyc;
            @(posedge clk);
            #1;
        end
        b.ibus_req_stb = 1'b0;
        b.dbus_req_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b.ibus_req_stb = 1'b0; b.dbus_req_stb = 1'b0;
        set_i('0);
        set_d(1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({b.core_cyc, b.core_stb, b.core_we, b.core_wstrb, b.core_addr, b.core_data_out} !== '0) begin errors++; $display("FAIL reset_core: got cyc=%b we=%b wstrb=%h addr=%h expected all 0", b.core_cyc, b.core_we, b.core_wstrb, b.core_addr); end
        checks++; if ({b.ibus_rsp_ack, b.ibus_rsp_err, b.ibus_rsp_data, b.dbus_rsp_ack, b.dbus_rsp_err, b.dbus_rsp_data} !== '0) begin errors++; $display("FAIL reset_rsp: got ibus ack/err/data=%b/%b/%h dbus=%b/%b/%h expected all 0", b.ibus_rsp_ack, b.ibus_rsp_err, b.ibus_rsp_data, b.dbus_rsp_ack, b.dbus_rsp_err, b.dbus_rsp_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_dbus_write();
        ack_wait = 2; log_q.delete(); unstable = 0;
        set_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        run(-1, 0, 12);
        checks++; if (d_acks !== 1 || d_errs !== 0) begin errors++; $display("FAIL wr_ack_count: got ack=%0d err=%0d expected 1/0", d_acks, d_errs); end
        checks++; if (d_t !== 5) begin errors++; $display("FAIL wr_latency: got cycle %0d expected 5", d_t); end
        checks++; if (d_dat !== 32'h0) begin errors++; $display("FAIL wr_rsp_data: got %h expected 0", d_dat); end
        checks++; if (cyc_hi !== 3 || unstable !== 0) begin errors++; $display("FAIL wr_bus_phase: got cyc cycles=%0d unstable=%0d expected 3/0", cyc_hi, unstable); end
        checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL wr_log_size: got %0d expected 1", log_q.size()); end
        else if ({log_q[0].we, log_q[0].addr, log_q[0].data, log_q[0].wstrb} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
            errors++; $display("FAIL wr_bus_fields: got we=%b addr=%h data=%h wstrb=%b expected 1/00000100/deadbeef/0011", log_q[0].we, log_q[0].addr, log_q[0].data, log_q[0].wstrb);
        end
    endtask

    task automatic test_ibus_read();
        ack_wait = 0; log_q.delete();
        set_i(32'h0);
        run(0, -1, 8);
        checks++; if (cyc_first !== 1) begin errors++; $display("FAIL rd_cyc_start: got cycle %0d expected 1", cyc_first); end
        checks++; if (i_acks !== 1 || i_t !== 3) begin errors++; $display("FAIL rd_latency: got %0d acks at cycle %0d expected 1 at 3", i_acks, i_t); end
        checks++; if (i_dat !== 32'h13) begin errors++; $display("FAIL rd_data: got %h expected 00000013", i_dat); end
        checks++; if (log_q.size() !== 1) begin errors++; $display("FAIL rd_log_size: got %0d expected 1", log_q.size()); end
        else if ({log_q[0].we, log_q[0].wstrb} !== {1'b0, 4'hF}) begin errors++; $display("FAIL rd_wstrb: got we=%b wstrb=%h expected 0/f", log_q[0].we, log_q[0].wstrb); end
    endtask

    task automatic test_simultaneous();
        ack_wait = 1; log_q.delete();
        set_i(32'h40);
        set_d(1'b0, 32'h200, 32'h1234_5678, 4'hF);
        run(0, 0, 16);
        checks++; if (d_acks !== 1 || i_acks !== 1) begin errors++; $display("FAIL sim_ack_counts: got dbus=%0d ibus=%0d expected 1/1", d_acks, i_acks); end
        checks++; if (d_t !== 4 || i_t !== 8) begin errors++; $display("FAIL sim_order: got dbus@%0d ibus@%0d expected 4/8", d_t, i_t); end
        checks++; if (phases !== 2 || cyc_hi !== 4) begin errors++; $display("FAIL sim_phases: got %0d phases %0d cyc cycles expected 2/4", phases, cyc_hi); end
        checks++; if (d_dat !== mem_rd(32'h200) || i_dat !== mem_rd(32'h40)) begin errors++; $display("FAIL sim_data: got dbus=%h ibus=%h expected %h/%h", d_dat, i_dat, mem_rd(32'h200), mem_rd(32'h40)); end
    endtask

    task automatic test_timeout();
        mem_en = 1'b0; log_q.delete();
        set_d(1'b0, 32'h300, 32'h0, 4'hF);
        run(-1, 0, 14);
        checks++; if (cyc_hi !== 8) begin errors++; $display("FAIL to_cyc_len: got %0d cycles expected 8", cyc_hi); end
        checks++; if (d_errs !== 1 || d_acks !== 0 || de_t !== 10) begin errors++; $display("FAIL to_err_pulse: got err=%0d@%0d ack=%0d expected 1@10/0", d_errs, de_t, d_acks); end
        checks++; if (b.dbus_rsp_data !== 32'h0) begin errors++; $display("FAIL to_rsp_data: got %h expected 0", b.dbus_rsp_data); end
        mem_en = 1'b1; ack_wait = 7;
        run(-1, 0, 16);
        checks++; if (d_acks !== 1 || d_errs !== 0 || d_t !== 10) begin errors++; $display("FAIL to_last_cycle_ack: got ack=%0d@%0d err=%0d expected 1@10/0", d_acks, d_t, d_errs); end
        checks++; if (d_dat !== mem_rd(32'h300)) begin errors++; $display("FAIL to_after_data: got %h expected %h", d_dat, mem_rd(32'h300)); end
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b0;
        set_d(1'b1, 32'h400, 32'hCAFE_F00D, 4'hF);
        run(-1, 0, 3);
        checks++; if (cyc_hi !== 2) begin errors++; $display("FAIL rm_in_flight: got %0d cyc cycles expected 2", cyc_hi); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({b.core_cyc, b.core_stb, b.ibus_rsp_ack, b.ibus_rsp_err, b.dbus_rsp_ack, b.dbus_rsp_err} !== 6'b0) begin errors++; $display("FAIL rm_drop: got cyc=%b stb=%b rsp=%b%b%b%b expected 0", b.core_cyc, b.core_stb, b.ibus_rsp_ack, b.ibus_rsp_err, b.dbus_rsp_ack, b.dbus_rsp_err); end
        @(posedge clk);
        #1;
        mem_en = 1'b1; stray_ack = 1'b1;
        run(-1, -1, 12);
        stray_ack = 1'b0;
        checks++; if (i_acks + i_errs + d_acks + d_errs + cyc_hi !== 0) begin errors++; $display("FAIL rm_no_response: got ibus=%0d/%0d dbus=%0d/%0d cyc=%0d expected none", i_acks, i_errs, d_acks, d_errs, cyc_hi); end
        ack_wait = 0;
        set_d(1'b0, 32'h600, 32'h0, 4'hF);
        run(-1, 0, 8);
        checks++; if (d_acks !== 1 || d_t !== 3 || d_dat !== mem_rd(32'h600)) begin errors++; $display("FAIL rm_recover: got %0d acks @%0d data %h expected 1@3 %h", d_acks, d_t, d_dat, mem_rd(32'h600)); end
    endtask

    task automatic test_ibus_during_dbus();
        ack_wait = 2;
        set_d(1'b0, 32'h500, 32'h0, 4'hF);
        set_i(32'h44);
        run(2, 0, 20);
        checks++; if (d_t !== 5 || i_t !== 10 || phases !== 2) begin errors++; $display("FAIL late_ibus: got dbus@%0d ibus@%0d phases=%0d expected 5/10/2", d_t, i_t, phases); end
        checks++; if (i_acks !== 1 || i_dat !== mem_rd(32'h44)) begin errors++; $display("FAIL late_ibus_data: got %0d acks data %h expected 1 %h", i_acks, i_dat, mem_rd(32'h44)); end
    endtask

    task automatic test_random();
        unstable = 0;
        for (int k = 0; k < 40; k++) begin
            int w, ti, td, ei, ed, di, ii;
            bit do_i, do_d;
            logic d_rw;
            logic [31:0] ia, da, dd;
            logic [3:0] ben;
            w = $urandom_range(0, 5);
            do_i = 1'($urandom); do_d = 1'($urandom);
            if (!do_i && !do_d) do_d = 1'b1;
            ti = do_i ? $urandom_range(0, 4) : -1;
            td = do_d ? $urandom_range(0, 4) : -1;
            ia = $urandom; da = $urandom; dd = $urandom; d_rw = 1'($urandom); ben = 4'($urandom_range(1, 15));
            ei = -1; ed = -1;
            if (do_i && do_d) begin
                if (td <= ti) begin ed = td + w + 3; ei = (ti > ed ? ti : ed) + w + 3; end
                else begin ei = ti + w + 3; ed = (td > ei ? td : ei) + w + 3; end
            end else if (do_i) ei = ti + w + 3;
            else ed = td + w + 3;
            di = (do_i && do_d && ti < td) ? 1 : 0;
            ii = (do_i && do_d && td <= ti) ? 1 : 0;
            ack_wait = w; log_q.delete();
            set_i(ia);
            set_d(d_rw, da, dd, ben);
            run(ti, td, 24);
            checks++; if (i_acks !== int'(do_i) || d_acks !== int'(do_d) || i_errs + d_errs !== 0) begin errors++; $display("FAIL rnd_counts[%0d]: got ibus=%0d dbus=%0d errs=%0d expected %0d/%0d/0", k, i_acks, d_acks, i_errs + d_errs, do_i, do_d); end
            checks++; if (i_t !== ei || d_t !== ed) begin errors++; $display("FAIL rnd_timing[%0d]: got ibus@%0d dbus@%0d expected %0d/%0d (w=%0d ti=%0d td=%0d)", k, i_t, d_t, ei, ed, w, ti, td); end
            if (do_i) begin
                checks++; if (i_dat !== mem_rd({ia[31:2], 2'b00})) begin errors++; $display("FAIL rnd_idata[%0d]: got %h expected %h", k, i_dat, mem_rd({ia[31:2], 2'b00})); end
            end
            if (do_d) begin
                checks++; if (d_dat !== (d_rw ? 32'h0 : mem_rd({da[31:2], 2'b00}))) begin errors++; $display("FAIL rnd_ddata[%0d]: got %h expected %h", k, d_dat, d_rw ? 32'h0 : mem_rd({da[31:2], 2'b00})); end
            end
            checks++; if (log_q.size() !== int'(do_i) + int'(do_d)) begin errors++; $display("FAIL rnd_log_size[%0d]: got %0d expected %0d", k, log_q.size(), int'(do_i) + int'(do_d)); end
            else begin
                if (do_d && {log_q[di].we, log_q[di].addr, log_q[di].wstrb, log_q[di].we ? log_q[di].data : 32'h0} !== {d_rw, da[31:2], 2'b00, d_rw ? ben : 4'hF, d_rw ? dd : 32'h0}) begin
                    errors++; $display("FAIL rnd_dbus_bus[%0d]: got we=%b addr=%h wstrb=%h data=%h expected %b/%h/%h/%h", k, log_q[di].we, log_q[di].addr, log_q[di].wstrb, log_q[di].data, d_rw, {da[31:2], 2'b00}, d_rw ? ben : 4'hF, dd);
                end
                if (do_i && {log_q[ii].we, log_q[ii].addr, log_q[ii].wstrb} !== {1'b0, ia[31:2], 2'b00, 4'hF}) begin
                    errors++; $display("FAIL rnd_ibus_bus[%0d]: got we=%b addr=%h wstrb=%h expected 0/%h/f", k, log_q[ii].we, log_q[ii].addr, log_q[ii].wstrb, {ia[31:2], 2'b00});
                end
            end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL rnd_stability: got %0d changes during cyc expected 0", unstable); end
    endtask

    initial begin
        test_reset();
        test_dbus_write();
        test_ibus_read();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_ibus_during_dbus();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
